// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the icache/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Word index within an icache line; line_words must be a power of two.
    function automatic int unsigned line_offset(input logic [63:0] addr,
                                                input int unsigned line_words);
        logic [63:0] word_idx;
        word_idx = addr >> 2;
        return word_idx[31:0] & (line_words - 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: line lock first, then data (bounded by streak), then icache.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_STREAK = 4,
    parameter int unsigned STREAK_W    = 3
) (
    input  logic                ic_req,
    input  logic                d_req,
    input  logic                lock,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_ic,
    output logic                grant_d
);

    localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(DATA_STREAK);

    logic ic_locked;
    logic d_ok;

    always_comb begin
        ic_locked = lock && ic_req;
        d_ok      = d_req && (!ic_req || (streak < StreakMax));
        grant_d   = !ic_locked && d_ok;
        grant_ic  = ic_locked || (ic_req && !d_ok);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, single-outstanding arbiter for the shared memory port (icache refill vs data).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned DATA_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ic_req,
    input  logic [ADDR_WIDTH-1:0]   ic_addr,
    output logic [DATA_WIDTH-1:0]   ic_data,
    output logic                    ic_valid,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_valid,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_rvalid
);

    localparam int unsigned STREAK_W = $clog2(DATA_STREAK) + 1;
    localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(DATA_STREAK);

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    lock_q, lock_d;
    logic [STREAK_W-1:0]     streak_q, streak_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH/8-1:0] mem_wstrb_q, mem_wstrb_d;

    logic grant_ic;
    logic grant_d;
    logic ic_match;
    logic line_end;

    mem_arb_pick #(
        .DATA_STREAK(DATA_STREAK),
        .STREAK_W   (STREAK_W)
    ) u_pick (
        .ic_req  (ic_req),
        .d_req   (d_req),
        .lock    (lock_q),
        .streak  (streak_q),
        .grant_ic(grant_ic),
        .grant_d (grant_d)
    );

    assign ic_match = ic_req && (ic_addr == mem_addr_q);
    assign line_end = line_offset(64'(mem_addr_q), LINE_WORDS) == (LINE_WORDS - 1);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        ic_valid    = 1'b0;
        ic_data     = '0;
        d_valid     = 1'b0;
        d_rdata     = '0;

        case (state_q)
            StIdle: begin
                if (!ic_req) begin
                    lock_d   = 1'b0;
                    streak_d = '0;
                end
                if (grant_d) begin
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_wstrb;
                    state_d     = StIssue;
                    if (ic_req && (streak_q != StreakMax)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (grant_ic) begin
                    owner_d     = OWN_IC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ic_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    streak_d    = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                    if (owner_q == OWN_D) begin
                        d_valid = 1'b1;
                        d_rdata = mem_rdata;
                    end else if (ic_match) begin
                        ic_valid = 1'b1;
                        ic_data  = mem_rdata;
                        lock_d   = !line_end;
                    end else begin
                        // Requester abandoned this word (e.g. invalidate): drop it, unlock line.
                        lock_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= OWN_IC;
            lock_q      <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model, per-cycle compare, literal pins.
module tb_mem_arbiter;

    localparam int LINE_WORDS  = 4;
    localparam int DATA_STREAK = 4;

    logic        clk;
    logic        rst_n;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [31:0] ic_data;
    logic        ic_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LINE_WORDS (LINE_WORDS),
        .DATA_STREAK(DATA_STREAK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_data   (ic_data),
        .ic_valid  (ic_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: ready after ready_delay issue cycles, response resp_delay cycles later.
    int          ready_delay = 0;
    int          resp_delay = 1;
    int          rk = 0;
    int          icnt = 0;
    logic        pend = 1'b0;
    logic        issuing;
    logic        req_s, rdy_s, rv_s;
    logic [31:0] a_s, a_lat;

    always @(posedge clk) begin
        req_s = mem_req;
        rdy_s = mem_ready;
        rv_s  = mem_rvalid;
        a_s   = mem_addr;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (rv_s) pend = 1'b0;
            if (req_s === 1'b1 && rdy_s) begin
                pend  = 1'b1;
                rk    = 1;
                a_lat = a_s;
            end else if (pend) begin
                rk++;
            end
        end
        issuing = rst_n && (req_s === 1'b1) && !rdy_s;
        #1;
        mem_rvalid = pend && (rk >= resp_delay);
        mem_rdata  = mem_rvalid ? (a_lat ^ 32'h5A5A_0000) : 32'h0;
        if (rst_n && mem_req === 1'b1) begin
            icnt      = issuing ? icnt + 1 : 0;
            mem_ready = (icnt >= ready_delay);
        end else begin
            icnt      = 0;
            mem_ready = 1'b0;
        end
    end

    // Behavioural model: one transaction record, a count of data grants while icache waits,
    // and whether an icache line is mid-refill.
    logic        live = 1'b0;
    logic        m_busy, m_acc, m_is_ic, m_we, m_line_open;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          m_drun;
    logic [31:0] m_grants[$];
    logic [31:0] dut_grants[$];

    wire m_pick_ic = ic_req && (m_line_open || !(d_req && (m_drun < DATA_STREAK)));
    wire m_pick_d  = !m_pick_ic && d_req;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy      <= 1'b0;
            m_acc       <= 1'b0;
            m_is_ic     <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            m_drun      <= 0;
            m_line_open <= 1'b0;
            live        <= 1'b1;
        end else if (live) begin
            if (!m_busy) begin
                if (!ic_req) m_line_open <= 1'b0;
                if (m_pick_ic || m_pick_d) begin
                    m_busy  <= 1'b1;
                    m_acc   <= 1'b0;
                    m_is_ic <= m_pick_ic;
                    m_addr  <= m_pick_ic ? ic_addr : d_addr;
                    m_we    <= m_pick_d && d_we;
                    m_wdata <= d_wdata;
                    m_wstrb <= m_pick_d ? d_wstrb : 4'h0;
                    m_grants.push_back(m_pick_ic ? ic_addr : d_addr);
                end
                m_drun <= (m_pick_d && ic_req) ?
                          ((m_drun < DATA_STREAK) ? m_drun + 1 : m_drun) : 0;
            end else if (!m_acc) begin
                if (mem_ready) m_acc <= 1'b1;
            end else if (mem_rvalid) begin
                m_busy <= 1'b0;
                if (m_is_ic) begin
                    m_line_open <= (ic_req && ic_addr == m_addr) &&
                                   (((m_addr >> 2) % LINE_WORDS) != LINE_WORDS - 1);
                end
            end
        end
    end

    wire exp_req  = m_busy && !m_acc;
    wire exp_resp = m_busy && m_acc && mem_rvalid;
    wire exp_icv  = exp_resp && m_is_ic && ic_req && (ic_addr == m_addr);
    wire exp_dv   = exp_resp && !m_is_ic;

    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (live) begin
            check("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we", 32'(mem_we), 32'(m_we));
                check("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
                if (!m_is_ic) check("mem_wdata", mem_wdata, m_wdata);
            end
            check("ic_valid", 32'(ic_valid), 32'(exp_icv));
            check("ic_data", ic_data, exp_icv ? mem_rdata : 32'h0);
            check("d_valid", 32'(d_valid), 32'(exp_dv));
            check("d_rdata", d_rdata, exp_dv ? mem_rdata : 32'h0);
            if (mem_req === 1'b1 && !req_prev) dut_grants.push_back(mem_addr);
            req_prev <= (mem_req === 1'b1);
        end
    end

    task automatic ic_fetch(input logic [31:0] a, output int lat, output logic [31:0] data);
        int   start;
        logic got;
        ic_addr = a;
        ic_req  = 1'b1;
        start   = cyc;
        got     = 1'b0;
        lat     = -1;
        data    = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (ic_valid === 1'b1) begin
                got  = 1'b1;
                lat  = cyc - start;
                data = ic_data;
            end
        end
        check("ic_valid_seen", 32'(got), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, output logic [31:0] rd);
        logic got;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_wstrb = ws;
        got     = 1'b0;
        rd      = '0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (d_valid === 1'b1) begin
                got = 1'b1;
                rd  = d_rdata;
            end
        end
        check("d_valid_seen", 32'(got), 32'd1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          base;
        int          icv_cnt;
        int          issue_cycles;
        int          bad;
        logic        got;
        logic [31:0] data;
        logic [31:0] rd;
        logic [31:0] exp_lock [5];
        logic [31:0] exp_starve [7];

        exp_lock   = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h2000};
        exp_starve = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h400, 32'h3010, 32'h3014};

        rst_n = 1'b0; ic_req = 1'b0; ic_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_ic_valid", 32'(ic_valid), 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single line refill, two-cycle latency per word.
        for (int k = 0; k < 4; k++) begin
            ic_fetch(32'h100 + 32'(4 * k), lat, data);
            check("ic_latency", 32'(lat), 32'd2);
            if (k == 0) check("ic_word0_data", data, 32'h5A5A_0100);
        end
        ic_req = 1'b0;
        @(posedge clk);
        #2;

        // Lock: data load raised after word 0 waits for the whole line.
        base = dut_grants.size();
        fork
            begin
                for (int k = 0; k < 4; k++) ic_fetch(32'h100 + 32'(4 * k), lat, data);
                ic_req = 1'b0;
            end
            begin
                got = 1'b0;
                for (int n = 0; n < 40 && !got; n++) begin
                    @(negedge clk);
                    if (ic_valid === 1'b1) got = 1'b1;
                end
                @(posedge clk);
                #2;
                d_access(1'b0, 32'h2000, 32'h0, 4'h0, rd);
                d_req = 1'b0;
                check("lock_load_data", rd, 32'h5A5A_2000);
            end
        join
        for (int i = 0; i < 5; i++) begin
            check("lock_grant_dut", dut_grants[base + i], exp_lock[i]);
            check("lock_grant_model", m_grants[base + i], exp_lock[i]);
        end

        // Starvation limit: four data grants, then icache, then data resumes.
        base = dut_grants.size();
        fork
            begin
                for (int k = 0; k < 6; k++) d_access(1'b0, 32'h3000 + 32'(4 * k), 32'h0, 4'h0, rd);
                d_req = 1'b0;
                check("starve_last_data", rd, 32'h5A5A_3014);
            end
            begin
                ic_fetch(32'h400, lat, data);
                ic_req = 1'b0;
                check("starve_ic_data", data, 32'h5A5A_0400);
            end
        join
        for (int i = 0; i < 7; i++) begin
            check("starve_grant_dut", dut_grants[base + i], exp_starve[i]);
            check("starve_grant_model", m_grants[base + i], exp_starve[i]);
        end

        // Abort: icache drops its request while the word 0x104 response is outstanding.
        resp_delay = 3;
        ic_fetch(32'h100, lat, data);
        ic_addr = 32'h104;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h2004;
        got     = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_ready && mem_addr == 32'h104) got = 1'b1;
        end
        check("abort_issue_seen", 32'(got), 32'd1);
        @(posedge clk);
        #2;
        ic_req  = 1'b0;
        icv_cnt = 0;
        got     = 1'b0;
        rd      = '0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (ic_valid === 1'b1) icv_cnt++;
            if (d_valid === 1'b1) begin
                got = 1'b1;
                rd  = d_rdata;
            end
        end
        check("abort_no_ic_valid", 32'(icv_cnt), 32'd0);
        check("abort_d_served", 32'(got), 32'd1);
        check("abort_d_data", rd, 32'h5A5A_2004);
        check("abort_grant_ic", dut_grants[dut_grants.size() - 2], 32'h104);
        check("abort_grant_d", dut_grants[dut_grants.size() - 1], 32'h2004);
        @(posedge clk);
        #2;
        d_req      = 1'b0;
        resp_delay = 1;
        @(posedge clk);
        #2;

        // Store with slow acceptance: request held stable for four issue cycles.
        ready_delay  = 3;
        d_req        = 1'b1;
        d_we         = 1'b1;
        d_addr       = 32'h3000;
        d_wdata      = 32'hDEAD_BEEF;
        d_wstrb      = 4'hF;
        issue_cycles = 0;
        bad          = 0;
        got          = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                issue_cycles++;
                if (mem_addr !== 32'h3000 || mem_wdata !== 32'hDEAD_BEEF ||
                    mem_we !== 1'b1 || mem_wstrb !== 4'hF) bad++;
            end
            if (d_valid === 1'b1) got = 1'b1;
        end
        check("store_issue_cycles", 32'(issue_cycles), 32'd4);
        check("store_fields_stable", 32'(bad), 32'd0);
        check("store_ack", 32'(got), 32'd1);
        @(posedge clk);
        #2;
        d_req = 1'b0;
        d_we  = 1'b0;
        @(posedge clk);
        #2;

        // Reset while the request is being issued.
        ready_delay = 6;
        d_req       = 1'b1;
        d_addr      = 32'h2008;
        got         = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (mem_req === 1'b1) got = 1'b1;
        end
        check("rst_issue_seen", 32'(got), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_ic_valid", 32'(ic_valid), 32'd0);
        check("midrst_d_valid", 32'(d_valid), 32'd0);
        @(posedge clk);
        #2;
        rst_n       = 1'b1;
        ready_delay = 0;
        d_access(1'b0, 32'h200C, 32'h0, 4'h0, rd);
        d_req = 1'b0;
        check("post_rst_load", rd, 32'h5A5A_200C);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
